// File: rtl/cmac_tx_kick_arbiter.sv
// Round-robin arbiter sharing one CMAC TX kick/busy/done handshake among
// NUM_REQ frame emitters, with a stuck-MAC timeout and an inter-grant gap.
//
// Ports:
//   clk, reset          single clock, synchronous active-high reset
//   req_kick/req_bytes  per-requester held request and packed 14-bit byte counts
//   req_ack/done/err    per-requester one-cycle status pulses
//   grant_valid/sel     datapath mux select for the granted requester
//   cmac_kick/bytes     kick and byte count towards the CMAC TX sequencer
//   cmac_busy/done      CMAC TX started / finished
//   stat_frames         completed frames (saturating)
//   stat_timeouts       timeouts (saturating)
module cmac_tx_kick_arbiter #(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned MAX_BYTES      = 9600,
    parameter int unsigned TIMEOUT_CYCLES = 65535,
    parameter int unsigned GAP_CYCLES     = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_kick,
    input  logic [NUM_REQ*14-1:0]      req_bytes,
    output logic [NUM_REQ-1:0]         req_ack,
    output logic [NUM_REQ-1:0]         req_done,
    output logic [NUM_REQ-1:0]         req_err,
    output logic                       grant_valid,
    output logic [$clog2(NUM_REQ)-1:0] grant_sel,
    output logic                       cmac_kick,
    output logic [13:0]                cmac_bytes,
    input  logic                       cmac_busy,
    input  logic                       cmac_done,
    output logic [31:0]                stat_frames,
    output logic [15:0]                stat_timeouts
);

    localparam int unsigned SEL_W    = $clog2(NUM_REQ);
    localparam int unsigned BYTES_W  = 14;
    localparam int unsigned TMO_W    = 16;
    localparam int unsigned GAP_W    = 4;
    localparam int unsigned FRAMES_W = 32;

    typedef enum logic [1:0] {
        S_IDLE,
        S_KICK,
        S_WAIT_DONE,
        S_GAP
    } state_t;

    state_t               state, state_nxt;
    logic [SEL_W-1:0]     last_grant, last_grant_nxt;
    logic [TMO_W-1:0]     tmo_cnt, tmo_cnt_nxt;
    logic [GAP_W-1:0]     gap_cnt, gap_cnt_nxt;

    logic [NUM_REQ-1:0]   req_ack_nxt, req_done_nxt, req_err_nxt;
    logic                 grant_valid_nxt, cmac_kick_nxt;
    logic [SEL_W-1:0]     grant_sel_nxt;
    logic [BYTES_W-1:0]   cmac_bytes_nxt;
    logic [FRAMES_W-1:0]  stat_frames_nxt;
    logic [TMO_W-1:0]     stat_timeouts_nxt;

    logic [BYTES_W-1:0]   bytes_arr [NUM_REQ];
    logic                 pick_valid;
    logic [SEL_W-1:0]     pick_sel;
    logic [SEL_W-1:0]     scan_idx;
    logic [BYTES_W-1:0]   pick_bytes;
    logic                 pick_legal;
    logic                 tmo_hit;
    logic                 gap_last;

    // Unpack the per-requester byte counts.
    always_comb begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            bytes_arr[i] = req_bytes[BYTES_W*i +: BYTES_W];
        end
    end

    // Round-robin scan starting just after the last granted requester.
    always_comb begin
        pick_valid = 1'b0;
        pick_sel   = '0;
        scan_idx   = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            scan_idx = SEL_W'((32'(last_grant) + k) % NUM_REQ);
            if (!pick_valid && req_kick[scan_idx]) begin
                pick_valid = 1'b1;
                pick_sel   = scan_idx;
            end
        end
    end

    assign pick_bytes = bytes_arr[pick_sel];
    assign pick_legal = (pick_bytes != '0) && (pick_bytes <= BYTES_W'(MAX_BYTES));
    // Fires on the TIMEOUT_CYCLES-th cycle spent in KICK or WAIT_DONE.
    assign tmo_hit    = (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
    assign gap_last   = (gap_cnt == GAP_W'(GAP_CYCLES - 1));

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_IDLE;
            last_grant    <= SEL_W'(NUM_REQ - 1);
            tmo_cnt       <= '0;
            gap_cnt       <= '0;
            req_ack       <= '0;
            req_done      <= '0;
            req_err       <= '0;
            grant_valid   <= 1'b0;
            grant_sel     <= '0;
            cmac_kick     <= 1'b0;
            cmac_bytes    <= '0;
            stat_frames   <= '0;
            stat_timeouts <= '0;
        end else begin
            state         <= state_nxt;
            last_grant    <= last_grant_nxt;
            tmo_cnt       <= tmo_cnt_nxt;
            gap_cnt       <= gap_cnt_nxt;
            req_ack       <= req_ack_nxt;
            req_done      <= req_done_nxt;
            req_err       <= req_err_nxt;
            grant_valid   <= grant_valid_nxt;
            grant_sel     <= grant_sel_nxt;
            cmac_kick     <= cmac_kick_nxt;
            cmac_bytes    <= cmac_bytes_nxt;
            stat_frames   <= stat_frames_nxt;
            stat_timeouts <= stat_timeouts_nxt;
        end
    end

    // Next-state logic; the handshake takes priority over the timeout.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (pick_valid) state_nxt = pick_legal ? S_KICK : S_GAP;
            end
            S_KICK: begin
                if (cmac_busy && cmac_done) state_nxt = S_GAP;
                else if (cmac_busy)         state_nxt = S_WAIT_DONE;
                else if (tmo_hit)           state_nxt = S_GAP;
            end
            S_WAIT_DONE: begin
                if (cmac_done || tmo_hit) state_nxt = S_GAP;
            end
            S_GAP: begin
                if (gap_last) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Next values of the registered outputs and counters.
    always_comb begin
        req_ack_nxt       = '0;
        req_done_nxt      = '0;
        req_err_nxt       = '0;
        grant_valid_nxt   = grant_valid;
        grant_sel_nxt     = grant_sel;
        cmac_kick_nxt     = cmac_kick;
        cmac_bytes_nxt    = cmac_bytes;
        stat_frames_nxt   = stat_frames;
        stat_timeouts_nxt = stat_timeouts;
        last_grant_nxt    = last_grant;
        tmo_cnt_nxt       = tmo_cnt;
        gap_cnt_nxt       = gap_cnt;
        case (state)
            S_IDLE: begin
                if (pick_valid) begin
                    last_grant_nxt = pick_sel;
                    if (pick_legal) begin
                        grant_valid_nxt = 1'b1;
                        grant_sel_nxt   = pick_sel;
                        cmac_bytes_nxt  = pick_bytes;
                        cmac_kick_nxt   = 1'b1;
                        tmo_cnt_nxt     = '0;
                    end else begin
                        req_ack_nxt[pick_sel] = 1'b1;
                        req_err_nxt[pick_sel] = 1'b1;
                        gap_cnt_nxt           = '0;
                    end
                end
            end
            S_KICK: begin
                tmo_cnt_nxt = tmo_cnt + TMO_W'(1);
                if (cmac_busy && cmac_done) begin
                    cmac_kick_nxt           = 1'b0;
                    grant_valid_nxt         = 1'b0;
                    req_ack_nxt[grant_sel]  = 1'b1;
                    req_done_nxt[grant_sel] = 1'b1;
                    stat_frames_nxt = (stat_frames == '1) ? stat_frames
                                                          : stat_frames + FRAMES_W'(1);
                    gap_cnt_nxt     = '0;
                end else if (cmac_busy) begin
                    cmac_kick_nxt          = 1'b0;
                    req_ack_nxt[grant_sel] = 1'b1;
                    tmo_cnt_nxt            = '0;
                end else if (tmo_hit) begin
                    cmac_kick_nxt          = 1'b0;
                    grant_valid_nxt        = 1'b0;
                    req_ack_nxt[grant_sel] = 1'b1;
                    req_err_nxt[grant_sel] = 1'b1;
                    stat_timeouts_nxt = (stat_timeouts == '1) ? stat_timeouts
                                                              : stat_timeouts + TMO_W'(1);
                    gap_cnt_nxt       = '0;
                end
            end
            S_WAIT_DONE: begin
                tmo_cnt_nxt = tmo_cnt + TMO_W'(1);
                if (cmac_done) begin
                    grant_valid_nxt         = 1'b0;
                    req_done_nxt[grant_sel] = 1'b1;
                    stat_frames_nxt = (stat_frames == '1) ? stat_frames
                                                          : stat_frames + FRAMES_W'(1);
                    gap_cnt_nxt     = '0;
                end else if (tmo_hit) begin
                    grant_valid_nxt        = 1'b0;
                    req_err_nxt[grant_sel] = 1'b1;
                    stat_timeouts_nxt = (stat_timeouts == '1) ? stat_timeouts
                                                              : stat_timeouts + TMO_W'(1);
                    gap_cnt_nxt       = '0;
                end
            end
            S_GAP: begin
                grant_valid_nxt = 1'b0;
                gap_cnt_nxt     = gap_cnt + GAP_W'(1);
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cmac_tx_kick_arbiter.sv
// Self-checking bench for cmac_tx_kick_arbiter: directed scenarios followed by
// randomized request/MAC timing, checked against a transaction-level model.
module tb_cmac_tx_kick_arbiter;

    localparam int unsigned NUM_REQ   = 4;
    localparam int unsigned MAX_BYTES = 9600;
    localparam int          TMO       = 16;
    localparam int          GAP       = 2;

    logic                    clk = 1'b0;
    logic                    reset;
    logic [NUM_REQ-1:0]      req_kick;
    logic [NUM_REQ*14-1:0]   req_bytes;
    logic [NUM_REQ-1:0]      req_ack, req_done, req_err;
    logic                    grant_valid;
    logic [1:0]              grant_sel;
    logic                    cmac_kick;
    logic [13:0]             cmac_bytes;
    logic                    cmac_busy, cmac_done;
    logic [31:0]             stat_frames;
    logic [15:0]             stat_timeouts;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int          m_last;
    int unsigned m_frames, m_timeouts;
    logic [13:0] bytes_arr [NUM_REQ];

    cmac_tx_kick_arbiter #(
        .NUM_REQ(NUM_REQ), .MAX_BYTES(MAX_BYTES),
        .TIMEOUT_CYCLES(TMO), .GAP_CYCLES(GAP)
    ) dut (
        .clk(clk), .reset(reset),
        .req_kick(req_kick), .req_bytes(req_bytes),
        .req_ack(req_ack), .req_done(req_done), .req_err(req_err),
        .grant_valid(grant_valid), .grant_sel(grant_sel),
        .cmac_kick(cmac_kick), .cmac_bytes(cmac_bytes),
        .cmac_busy(cmac_busy), .cmac_done(cmac_done),
        .stat_frames(stat_frames), .stat_timeouts(stat_timeouts)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [NUM_REQ-1:0] onehot(input int i);
        logic [NUM_REQ-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // First requesting index after `last`, wrapping; -1 when none.
    function automatic int rr_pick(input logic [NUM_REQ-1:0] r, input int last);
        for (int k = 1; k <= NUM_REQ; k++) begin
            int idx;
            idx = (last + k) % NUM_REQ;
            if (r[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic int rand_bytes();
        int r;
        r = $urandom_range(0, 11);
        case (r)
            0:       return 0;
            1:       return $urandom_range(MAX_BYTES + 1, 16383);
            2:       return MAX_BYTES;
            3:       return 1;
            default: return $urandom_range(1, MAX_BYTES);
        endcase
    endfunction

    task automatic set_req(input int i, input int nb);
        bytes_arr[i]          = 14'(nb);
        req_bytes[14*i +: 14] = 14'(nb);
        req_kick[i]           = 1'b1;
    endtask

    task automatic raise_random();
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!req_kick[i] && $urandom_range(0, 2) == 0) set_req(i, rand_bytes());
        end
    endtask

    task automatic check_cycle(input string tag, input logic gv, input logic kick,
                               input logic [NUM_REQ-1:0] ack,
                               input logic [NUM_REQ-1:0] done,
                               input logic [NUM_REQ-1:0] err);
        check_eq({tag, ".grant_valid"}, grant_valid, gv);
        check_eq({tag, ".cmac_kick"},   cmac_kick,   kick);
        check_eq({tag, ".req_ack"},     req_ack,     ack);
        check_eq({tag, ".req_done"},    req_done,    done);
        check_eq({tag, ".req_err"},     req_err,     err);
    endtask

    task automatic check_stats(input string tag);
        check_eq({tag, ".stat_frames"},   stat_frames,   m_frames);
        check_eq({tag, ".stat_timeouts"}, stat_timeouts, m_timeouts);
    endtask

    task automatic check_all_zero(input string tag);
        check_cycle(tag, 1'b0, 1'b0, '0, '0, '0);
        check_eq({tag, ".grant_sel"},  grant_sel,  0);
        check_eq({tag, ".cmac_bytes"}, cmac_bytes, 0);
        check_eq({tag, ".stat_frames"},   stat_frames,   0);
        check_eq({tag, ".stat_timeouts"}, stat_timeouts, 0);
    endtask

    // One arbitration starting with the arbiter in IDLE.  b = cycle after the
    // kick on which busy is driven, same = done with busy, dd = done delay
    // after busy.  Ends with the arbiter back in IDLE.
    task automatic run_episode(input int b, input bit same, input int dd, input bit noisy);
        int          sel, t_end;
        logic [13:0] nb;
        bit          legal, k_ack, k_done, k_err;
        sel = rr_pick(req_kick, m_last);
        if (sel < 0) begin
            step();
            check_cycle("idle", 1'b0, 1'b0, '0, '0, '0);
            return;
        end
        m_last = sel;
        nb     = bytes_arr[sel];
        legal  = (nb != 0) && (32'(nb) <= MAX_BYTES);
        step();
        if (!legal) begin
            check_cycle("len_err", 1'b0, 1'b0, onehot(sel), '0, onehot(sel));
            check_stats("len_err");
            req_kick[sel] = 1'b0;
        end else begin
            check_cycle("grant", 1'b1, 1'b1, '0, '0, '0);
            check_eq("grant.grant_sel",  grant_sel,  sel);
            check_eq("grant.cmac_bytes", cmac_bytes, nb);
            if (b <= TMO) begin
                if (same)           begin t_end = b;       k_ack = 1; k_done = 1; k_err = 0; end
                else if (dd <= TMO) begin t_end = b + dd;  k_ack = 0; k_done = 1; k_err = 0; end
                else                begin t_end = b + TMO; k_ack = 0; k_done = 0; k_err = 1; end
            end else begin
                t_end = TMO; k_ack = 1; k_done = 0; k_err = 1;
            end
            if (noisy && $urandom_range(0, 9) == 0) req_kick[sel] = 1'b0;
            for (int c = 1; c <= t_end; c++) begin
                cmac_busy = (c == b) || (noisy && c > b && $urandom_range(0, 1) == 1);
                cmac_done = (c == b && same) || (!same && c == b + dd);
                step();
                cmac_busy = 1'b0;
                cmac_done = 1'b0;
                if (c < t_end) begin
                    check_cycle("active", 1'b1, (c < b), (c == b) ? onehot(sel) : '0, '0, '0);
                    check_eq("active.grant_sel", grant_sel, sel);
                    if (c == b) req_kick[sel] = 1'b0;
                end else begin
                    if (k_done) m_frames++;
                    if (k_err)  m_timeouts++;
                    check_cycle("finish", 1'b0, 1'b0,
                                k_ack  ? onehot(sel) : '0,
                                k_done ? onehot(sel) : '0,
                                k_err  ? onehot(sel) : '0);
                    check_stats("finish");
                    if (k_ack) req_kick[sel] = 1'b0;
                end
            end
        end
        for (int g = 0; g < GAP; g++) begin
            if (noisy) begin
                cmac_busy = 1'($urandom_range(0, 1));
                cmac_done = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 3) == 0) raise_random();
            end
            step();
            check_cycle("gap", 1'b0, 1'b0, '0, '0, '0);
        end
        cmac_busy = 1'b0;
        cmac_done = 1'b0;
    endtask

    task automatic drain();
        for (int n = 0; n < 2 * NUM_REQ && req_kick != '0; n++) run_episode(1, 0, 1, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        req_kick  = '0;
        req_bytes = '0;
        cmac_busy = 1'b0;
        cmac_done = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) bytes_arr[i] = '0;
        step();
        step();
        check_all_zero("reset");
        reset      = 1'b0;
        m_last     = NUM_REQ - 1;
        m_frames   = 0;
        m_timeouts = 0;

        // Fairness: all four held, then requester 0 again while 1..3 wait.
        for (int k = 0; k < 8; k++) begin
            if (k == 0 || k == 4)
                for (int i = 0; i < NUM_REQ; i++) if (!req_kick[i]) set_req(i, 64 + 10 * i + k);
            run_episode(2, 0, 3, 0);
        end

        // Single request, busy 3 cycles after kick, done 10 later.
        set_req(0, 100);
        run_episode(3, 0, 10, 0);

        // Length errors.
        set_req(2, 0);
        run_episode(1, 0, 1, 0);
        set_req(2, 9601);
        run_episode(1, 0, 1, 0);

        // Kick timeout, then the next requester.
        set_req(1, 500);
        run_episode(1000, 0, 0, 0);
        set_req(2, 200);
        run_episode(2, 0, 2, 0);

        // Corners: busy+done together, done on timeout cycle, busy on timeout cycle,
        // done never arrives.
        set_req(3, 64);
        run_episode(2, 1, 0, 0);
        set_req(0, 1500);
        run_episode(1, 0, TMO, 0);
        set_req(1, MAX_BYTES);
        run_episode(TMO, 0, 2, 0);
        set_req(2, 1);
        run_episode(4, 0, 1000, 0);

        // Random traffic.
        for (int n = 0; n < 200; n++) begin
            raise_random();
            run_episode($urandom_range(1, 20), ($urandom_range(0, 4) == 0),
                        $urandom_range(1, 20), 1);
        end
        drain();

        // Reset in WAIT_DONE.
        set_req(2, 777);
        step();
        check_eq("rst_pre.grant_sel", grant_sel, 2);
        check_eq("rst_pre.cmac_kick", cmac_kick, 1);
        cmac_busy = 1'b1;
        step();
        cmac_busy = 1'b0;
        check_eq("rst_pre.req_ack", req_ack, onehot(2));
        req_kick[2] = 1'b0;
        step();
        step();
        check_cycle("rst_wait", 1'b1, 1'b0, '0, '0, '0);
        reset = 1'b1;
        step();
        check_all_zero("reset_mid");
        reset      = 1'b0;
        m_last     = NUM_REQ - 1;
        m_frames   = 0;
        m_timeouts = 0;
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 100 + i);
        run_episode(2, 0, 2, 0);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cmac_tx_kick_arbiter.md
Name: cmac_tx_kick_arbiter

Overview:
- Shares one CMAC TX kick/busy/done handshake among NUM_REQ frame emitters.
- Each emitter presents a buffered frame via a held request and a byte count.
- Block picks one requester round-robin, drives the datapath mux select and the CMAC kick, tracks busy/done, and returns per-requester ack/done/error pulses.
- Sits between the per-source emitters and the CMAC TX sequencer; includes a timeout for a stuck MAC.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- MAX_BYTES, 9600, largest legal frame byte count.
- TIMEOUT_CYCLES, 65535, cycles allowed in KICK or WAIT_DONE before abort (fits 16 bits).
- GAP_CYCLES, 2, idle cycles forced between grants (1..15).

Ports:
- clk  in  1  single clock.
- reset  in  1  synchronous, active-high.
- req_kick  in  NUM_REQ  per-requester level request; held high until that requester's req_ack pulse.
- req_bytes  in  NUM_REQ*14  packed byte counts; slice i = [14*i+13:14*i]; stable while req_kick[i] is high.
- req_ack  out  NUM_REQ  one-cycle pulse: frame accepted, or rejected/aborted before acceptance.
- req_done  out  NUM_REQ  one-cycle pulse: CMAC reported TX done.
- req_err  out  NUM_REQ  one-cycle pulse: length error or timeout.
- grant_valid  out  1  grant_sel is valid; datapath mux follows it.
- grant_sel  out  $clog2(NUM_REQ)  index of the granted requester.
- cmac_kick  out  1  kick to CMAC TX sequencer.
- cmac_bytes  out  14  byte count of the granted frame.
- cmac_busy  in  1  CMAC TX has begun.
- cmac_done  in  1  CMAC TX finished.
- stat_frames  out  32  completed frames; saturates at all-ones.
- stat_timeouts  out  16  timeouts; saturates at all-ones.

Behaviour:
- Reset: all outputs 0 (including pulses, counters, grant_sel); state IDLE; round-robin pointer last_grant = NUM_REQ-1, so requester 0 has first priority.
- All outputs are registered.
- IDLE:
  - If any req_kick bit is set, select the first set bit scanning from last_grant+1 with wrap; last_grant <= sel.
  - Length legal (1..MAX_BYTES): next cycle grant_valid=1, grant_sel=sel, cmac_bytes=req_bytes[sel], cmac_kick=1 -> KICK. Latency from req_kick seen in IDLE to cmac_kick high is 1 cycle.
  - Length illegal (0 or >MAX_BYTES): pulse req_ack[sel] and req_err[sel], no kick, grant_valid stays 0 -> GAP.
- KICK:
  - cmac_kick held high.
  - On cmac_busy: cmac_kick<=0, pulse req_ack[sel] -> WAIT_DONE.
  - If cmac_busy and cmac_done arrive in the same cycle: pulse req_ack and req_done together, stat_frames++ -> GAP.
- WAIT_DONE: on cmac_done, pulse req_done[sel], stat_frames++ -> GAP.
- Timeout:
  - A 16-bit counter clears on entry to KICK and WAIT_DONE and increments each cycle in those states.
  - On reaching TIMEOUT_CYCLES: cmac_kick<=0, pulse req_err[sel], stat_timeouts++ -> GAP.
  - If the timeout hits in KICK, req_ack[sel] is also pulsed so the requester releases.
  - If cmac_busy or cmac_done arrives on the timeout cycle, the handshake wins and no error is raised.
- GAP:
  - grant_valid<=0.
  - Count GAP_CYCLES, then -> IDLE.
  - Requests arriving during GAP wait for IDLE.
- cmac_busy/cmac_done are ignored outside KICK/WAIT_DONE, except busy+done in the same KICK cycle as defined above.
- A requester dropping req_kick before its ack is a protocol violation: the grant proceeds unchanged.
- Reset mid-operation: immediate return to IDLE with outputs cleared, counters cleared, pointer reinitialised; no pulses emitted.
- Exactly one bit of req_ack/req_done/req_err is high at a time, always at index grant_sel (or sel for a length error).

Test Plan:
- Single request: req_kick=0001, bytes0=100; busy 3 cycles after kick, done 10 cycles later -> cmac_kick high 1 cycle after request; cmac_bytes=100; grant_sel=0; req_ack[0] on the busy cycle; req_done[0] on the done cycle; stat_frames=1.
- Fairness: req_kick=1111 held, each serviced -> grant order 0,1,2,3,0; ≥GAP_CYCLES=2 idle cycles with grant_valid=0 between grants.
- Length error: bytes2=0, then bytes2=9601 -> req_ack[2] and req_err[2] pulse, cmac_kick never rises, stat_frames unchanged.
- Timeout: TIMEOUT_CYCLES=16, busy never asserted -> cmac_kick drops after 16 cycles; req_ack and req_err pulse; stat_timeouts=1; next requester granted after the gap.
- Corner cases:
  - busy and done in the same cycle -> ack and done pulse together.
  - done on the exact timeout cycle -> no err, stat_timeouts unchanged.
  - reset asserted in WAIT_DONE -> all outputs 0 next cycle; next grant goes to requester 0.
